// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing the single-port boot ROM between TCDM-style masters.
// Illegal accesses (writes, out-of-window, locked) get a local error response with the same 1-cycle latency.
module boot_rom_arbiter #(
  parameter int unsigned              NB_MASTERS     = 3,
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter int unsigned              DATA_WIDTH     = 40,
  parameter logic [ADDR_WIDTH-1:0]    ROM_START_ADDR = 32'h1A00_0000,
  parameter int unsigned              ROM_SIZE       = 8192,
  parameter logic [DATA_WIDTH-1:0]    ERR_DATA       = 40'hBA_DDEC_0DE0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  lock_i,
  input  logic [NB_MASTERS-1:0]                 req_i,
  input  logic [NB_MASTERS-1:0]                 wen_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] add_i,
  output logic [NB_MASTERS-1:0]                 gnt_o,
  output logic [NB_MASTERS-1:0]                 r_valid_o,
  output logic [DATA_WIDTH-1:0]                 r_rdata_o,
  output logic                                  r_opc_o,
  output logic                                  rom_req_o,
  output logic [ADDR_WIDTH-1:0]                 rom_add_o,
  input  logic                                  rom_gnt_i,
  input  logic                                  rom_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                 rom_r_rdata_i
);

  localparam int unsigned IDX_W = $clog2(NB_MASTERS);
  localparam logic [ADDR_WIDTH:0] ROM_SIZE_W = (ADDR_WIDTH+1)'(ROM_SIZE);
  localparam logic [IDX_W:0] NB_W = (IDX_W+1)'(NB_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MASTERS - 1);

  // One extra bit keeps addresses below the window from wrapping into a false hit.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] ofs;
    ofs = {1'b0, addr} - {1'b0, ROM_START_ADDR};
    return ofs < ROM_SIZE_W;
  endfunction

  logic [IDX_W-1:0] rr_q;
  logic             resp_vld_q;
  logic [IDX_W-1:0] resp_idx_q;
  logic             resp_err_q;

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             found;
  logic             any_req;
  logic             win_legal;
  logic             granted;

  // Stage 0: combinational arbitration and grant
  always_comb begin
    any_req = |req_i;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= NB_W) cand = cand - NB_W;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    win_legal = req_i[win_idx] & wen_i[win_idx] & ~lock_i & in_window(add_i[win_idx]);
    granted   = any_req & (win_legal ? rom_gnt_i : 1'b1);
    gnt_o     = '0;
    if (any_req) gnt_o[win_idx] = win_legal ? rom_gnt_i : 1'b1;
    rom_req_o = win_legal;
    rom_add_o = add_i[win_idx];
  end

  // Stage 1: pointer and response tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      resp_vld_q <= 1'b0;
      resp_idx_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (granted) rr_q <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      resp_vld_q <= granted;
      resp_idx_q <= win_idx;
      resp_err_q <= ~win_legal;
    end
  end

  always_comb begin
    r_valid_o             = '0;
    r_valid_o[resp_idx_q] = resp_vld_q;
    r_rdata_o             = resp_err_q ? ERR_DATA : rom_r_rdata_i;
    r_opc_o               = resp_vld_q & resp_err_q;
  end

  // A legal grant must see the ROM answer exactly one cycle later.
  rom_rvalid_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    (resp_vld_q && !resp_err_q) |-> rom_r_valid_i);

endmodule

// File: doc/boot_rom_arbiter.md
# boot_rom_arbiter

Round-robin arbiter that shares the single-port boot ROM between NB_MASTERS TCDM-style requesters. Typical requesters are the FC instruction port, the FC data port and the debug module. It sits between the SoC interconnect ports and the boot ROM slave. The arbiter grants one read per cycle, routes the fixed 1-cycle-latency response back to the winning master, and answers illegal accesses locally with an error response. Illegal accesses are writes, out-of-window addresses, and any access after the ROM is locked.

## Interface
Parameters:
- NB_MASTERS, 3: number of requesters (2..8)
- ADDR_WIDTH, 32: byte address width
- DATA_WIDTH, 40: ROM word width
- ROM_START_ADDR, 32'h1A00_0000: first byte address of the ROM window
- ROM_SIZE, 8192: window size in bytes, power of two
- ERR_DATA, 40'hBA_DDEC_0DE0: rdata returned on an error response

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lock_i  in  1  level; when high, all new ROM accesses return an error
- req_i  in  NB_MASTERS  per-master request
- wen_i  in  NB_MASTERS  per-master write enable, active-low (0 = write)
- add_i  in  NB_MASTERS x ADDR_WIDTH  per-master byte address
- gnt_o  out  NB_MASTERS  per-master grant, combinational
- r_valid_o  out  NB_MASTERS  per-master response valid
- r_rdata_o  out  DATA_WIDTH  response data, shared by all masters
- r_opc_o  out  1  response error flag (1 = error)
- rom_req_o  out  1  ROM request
- rom_add_o  out  ADDR_WIDTH  ROM byte address, forwarded unmodified
- rom_gnt_i  in  1  ROM grant (the ROM ties it to rom_req_o)
- rom_r_valid_i  in  1  ROM response valid, one cycle after grant
- rom_r_rdata_i  in  DATA_WIDTH  ROM response data

## Operation
- **Legal access:** req_i[m] & wen_i[m] & ~lock_i & (ROM_START_ADDR <= add_i[m] < ROM_START_ADDR+ROM_SIZE).
  - Compute the window check as an unsigned ADDR_WIDTH+1-bit subtraction, so no wrap-around false hits occur.
- **Arbitration:**
  - Round-robin over all masters with req_i high, legal and illegal alike.
  - Pointer rr_q (clog2(NB_MASTERS) bits): the search starts at rr_q, and index NB_MASTERS-1 wraps to 0.
  - Exactly one gnt_o bit is high in any cycle with at least one request.
- **Legal winner:**
  - rom_req_o=1 and rom_add_o=add_i[winner].
  - gnt_o[winner] = rom_gnt_i.
- **Illegal winner:**
  - rom_req_o=0 and gnt_o[winner]=1 locally.
  - The error flag is registered for the response.
- **Pointer update:** on any grant, rr_q <= winner+1 (mod NB_MASTERS). With no grant, rr_q holds.
- **Response tracking registers:**
  - resp_vld_q, resp_idx_q and resp_err_q are loaded every cycle.
  - resp_vld_q <= any grant.
- **Response outputs:**
  - r_valid_o[resp_idx_q] = resp_vld_q; all other bits are 0.
  - r_rdata_o = resp_err_q ? ERR_DATA : rom_r_rdata_i.
  - r_opc_o = resp_vld_q & resp_err_q.
- **ROM handshake check:** a legal grant must be followed by rom_r_valid_i one cycle later.
  - If rom_r_valid_i is 0 while resp_vld_q=1 and resp_err_q=0, the arbiter still asserts r_valid_o.
  - A simulation-only assertion flags the violation.
- **Lock:** lock_i is sampled in the grant cycle. A lock edge never affects a response already in flight.

## Timing
- Reset values: rr_q=0, resp_vld_q=0, resp_idx_q=0, resp_err_q=0.
  - Hence r_valid_o=0 and r_opc_o=0 during and after reset.
  - gnt_o and rom_req_o are 0 whenever req_i=0.
- **Grant:** same cycle as the request (combinational, TCDM protocol). The master holds req and add until granted.
- **Response latency:** exactly 1 cycle after the grant, for both legal and error accesses.
- **Throughput:** one grant per cycle, with back-to-back grants allowed. The response of grant N coincides with grant N+1.
- **Fairness:** with all masters requesting continuously, each master is granted once every NB_MASTERS cycles.
- **Simultaneous events:** a response and a new grant to the same master in the same cycle are legal; both r_valid_o[m] and gnt_o[m] are high.
- **Reset mid-operation:** asserting rst_i drops the in-flight response, so r_valid_o is never asserted. rr_q returns to 0.

## Test plan
- **Reset and single read:** reset, then master 0 reads 32'h1A00_0010 -> gnt_o=3'b001 in the same cycle, rom_add_o=32'h1A00_0010, r_valid_o=3'b001 next cycle, r_rdata_o equals ROM word 4, r_opc_o=0.
- **All masters requesting for 6 cycles from reset:** grants are 001,010,100,001,010,100, and each r_valid_o follows its grant by one cycle with the matching data.
- **Error accesses:**
  - Master 1 writes (wen_i=0) to 32'h1A00_0000 -> rom_req_o=0, gnt_o=3'b010, next cycle r_valid_o=3'b010, r_opc_o=1, r_rdata_o=ERR_DATA.
  - Same response for a read to 32'h1A00_2000, which is ROM_START_ADDR+ROM_SIZE (the first byte outside the window).
- **Lock:**
  - Master 2 read granted, then lock_i rises in the next cycle -> that response is still normal ROM data with r_opc_o=0.
  - A subsequent read by master 2 -> r_opc_o=1 and rom_req_o=0.
- **Mixed back-to-back:** master 0 legal and master 1 illegal, both requesting for 4 cycles starting at rr_q=0 -> alternating grants, with responses alternating ROM data/r_opc_o=0 and ERR_DATA/r_opc_o=1.
- **Reset mid-operation:** assert rst_i in the cycle after a grant -> no r_valid_o pulse; after release, a master 1 request is granted ahead of master 0 only if master 0 is idle (rr_q=0).
